// File: rtl/upzero_param.sv
// ADPCM zero-section predictor update: sign-sign LMS with leakage over NTAPS taps, then delay-line shift.
// Latency: ap_done/ap_ready pulse NTAPS+2 cycles after the start-accept cycle (one tap per cycle).
// Backpressure: none; ap_start is ignored outside IDLE. Optional key lock via UPZERO_LOCK_EN.
`timescale 1ns/1ps
module upzero_param #(
    parameter int NTAPS                = 6,
    parameter int DW                   = 17,
    parameter int CW                   = 32,
    parameter int LEAK_SH              = 8,
    parameter int STEP                 = 128,
    parameter int KEY_W                = 21,
    parameter logic [KEY_W-1:0] LOCK_KEY = '0,
    localparam int AW                  = $clog2(NTAPS)
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_idle,
    output logic                 ap_ready,
    input  logic signed [DW-1:0] dlt,
`ifdef UPZERO_LOCK_EN
    input  logic [KEY_W-1:0]     working_key,
`endif
    input  logic                 rd_sel,
    input  logic [AW-1:0]        rd_addr,
    output logic [CW-1:0]        rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] STEP_V   = CW'(STEP);
    localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       bli  [NTAPS];
    logic [CW-1:0]       dlti [NTAPS];
    logic [CW-1:0]       dlt_q;
    logic [AW-1:0]       tap_q;

    logic [CW-1:0]        cur_b, cur_d, diff, upd, bli_wr;
    logic signed [CW-1:0] leaked;
    logic                 neg_step;
    logic                 last_tap;

    assign last_tap = (tap_q == LAST_TAP);

    always_comb begin
        cur_b  = bli[tap_q];
        cur_d  = dlti[tap_q];
        diff   = (cur_b << LEAK_SH) - cur_b;
        leaked = $signed(diff) >>> LEAK_SH;
        // Sign of dlt*dlti from the operand MSBs; a zero delay-line entry counts as positive.
        neg_step = (dlt_q[CW-1] ^ cur_d[CW-1]) & (cur_d != '0);
        if (dlt_q == '0) begin
            upd = leaked;
        end else if (neg_step) begin
            upd = leaked - STEP_V;
        end else begin
            upd = leaked + STEP_V;
        end
`ifdef UPZERO_LOCK_EN
        bli_wr = (working_key != LOCK_KEY) ? (upd ^ CW'(1)) : upd;
`else
        bli_wr = upd;
`endif
    end

    always_comb begin
        state_d  = state_q;
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        ap_idle  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_d = S_UPD;
                end
            end
            S_UPD: begin
                if (last_tap) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: state_d = S_DONE;
            S_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            dlt_q   <= '0;
            tap_q   <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                bli[k]  <= '0;
                dlti[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        dlt_q <= CW'(dlt);
                        tap_q <= '0;
                    end
                end
                S_UPD: begin
                    bli[tap_q] <= bli_wr;
                    if (!last_tap) begin
                        tap_q <= tap_q + AW'(1);
                    end
                end
                S_SHIFT: begin
                    for (int k = NTAPS - 1; k > 0; k--) begin
                        dlti[k] <= dlti[k-1];
                    end
                    dlti[0] <= dlt_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < (AW+1)'(NTAPS)) begin
            rd_data = rd_sel ? dlti[rd_addr] : bli[rd_addr];
        end
    end

endmodule

// File: tb/tb_upzero_param.sv
// Scoreboarded random/directed bench for upzero_param against an arithmetic reference model.
`timescale 1ns/1ps
module tb_upzero_param;
    localparam int NTAPS = 6, DW = 17, CW = 32, LEAK_SH = 8, STEP = 128, KEY_W = 21;
    localparam int AW = $clog2(NTAPS);

    logic                 ap_clk = 1'b0;
    logic                 ap_rst_n = 1'b0;
    logic                 ap_start = 1'b0;
    logic                 ap_done, ap_idle, ap_ready;
    logic signed [DW-1:0] dlt = '0;
    logic                 rd_sel = 1'b0;
    logic [AW-1:0]        rd_addr = '0;
    logic [CW-1:0]        rd_data;
`ifdef UPZERO_LOCK_EN
    logic [KEY_W-1:0]     working_key = KEY_W'(1);
`endif

    upzero_param #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .LEAK_SH(LEAK_SH), .STEP(STEP), .KEY_W(KEY_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .dlt(dlt),
`ifdef UPZERO_LOCK_EN
        .working_key(working_key),
`endif
        .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic signed [CW-1:0] b [NTAPS];
        logic signed [CW-1:0] d [NTAPS];
        int                   acc_cyc;
    } exp_t;

    exp_t                 exp_q[$];
    logic signed [CW-1:0] m_b [NTAPS];
    logic signed [CW-1:0] m_d [NTAPS];
    int checks = 0, failures = 0;
    int cyc = 0;
    int dump_req = 0, dump_seen = 0;

    always @(posedge ap_clk) cyc++;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic signed [CW-1:0] leak(input logic signed [CW-1:0] b);
        logic signed [CW-1:0] t;
        t = b * (2 ** LEAK_SH) - b;
        return t >>> LEAK_SH;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NTAPS; i++) begin
            m_b[i] = '0;
            m_d[i] = '0;
        end
    endtask

    task automatic model_step(input logic signed [DW-1:0] x);
        logic signed [CW-1:0] xe, nb;
        xe = x;
        for (int i = 0; i < NTAPS; i++) begin
            nb = leak(m_b[i]);
            if (xe != 0) begin
                if (m_d[i] != 0 && ((xe < 0) != (m_d[i] < 0))) nb = nb - STEP;
                else nb = nb + STEP;
            end
`ifdef UPZERO_LOCK_EN
            nb = nb ^ CW'(1);
`endif
            m_b[i] = nb;
        end
        for (int k = NTAPS - 1; k > 0; k--) m_d[k] = m_d[k-1];
        m_d[0] = xe;
    endtask

    // Sweeps every readout address (including out-of-range ones) within a single cycle.
    task automatic compare_entries(input logic signed [CW-1:0] eb [NTAPS], input logic signed [CW-1:0] ed [NTAPS]);
        for (int i = 0; i < (1 << AW); i++) begin
            rd_addr = AW'(i);
            rd_sel = 1'b0;
            #0.25;
            chk($sformatf("bli[%0d]", i), $signed(rd_data), (i < NTAPS) ? eb[i] : 0);
            rd_sel = 1'b1;
            #0.25;
            chk($sformatf("dlti[%0d]", i), $signed(rd_data), (i < NTAPS) ? ed[i] : 0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge ap_clk);
            #1;
            if (ap_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("accept_to_done_edges", cyc - e.acc_cyc, NTAPS + 1);
                    chk("ready_with_done", ap_ready, 1);
                    chk("idle_in_done", ap_idle, 0);
                    compare_entries(e.b, e.d);
                    @(posedge ap_clk);
                    #1;
                    chk("done_width", ap_done, 0);
                    chk("idle_after_done", ap_idle, 1);
                end
            end else if (dump_seen != dump_req) begin
                chk("idle_dump", ap_idle, 1);
                chk("done_dump", ap_done, 0);
                compare_entries(m_b, m_d);
                dump_seen++;
            end
        end
    end

    task automatic request_dump();
        int t;
        dump_req++;
        t = 0;
        while (dump_seen != dump_req && t < 10) begin
            @(negedge ap_clk);
            t++;
        end
        chk("dump_timeout", dump_seen, dump_req);
        dump_seen = dump_req;
    endtask

    task automatic do_txn(input logic signed [DW-1:0] x, input bit hold);
        exp_t e;
        int t;
        @(negedge ap_clk);
        t = 0;
        while (ap_idle !== 1'b1 && t < 20) begin
            @(negedge ap_clk);
            t++;
        end
        dlt = x;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        model_step(x);
        e.b = m_b;
        e.d = m_d;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        if (!hold) ap_start = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge ap_clk);
            t++;
        end
        chk("done_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin : stimulus
        logic signed [DW-1:0] x;
        model_reset();
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        request_dump();

        do_txn(17'sd100, 1'b0);
        do_txn(-17'sd50, 1'b0);
        do_txn(17'sd0, 1'b0);

        // Abort three cycles into the update sweep; nothing of it may survive.
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #2;
        ap_rst_n = 1'b1;
        model_reset();
        @(negedge ap_clk);
        dlt = 17'sd100;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (3) @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        request_dump();
        do_txn(17'sd100, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: x = '0;
                1: x = {1'b1, {(DW-1){1'b0}}};
                2: x = {1'b0, {(DW-1){1'b1}}};
                3: x = DW'($signed($urandom_range(0, 200)) - 100);
                default: x = DW'($urandom);
            endcase
            do_txn(x, $urandom_range(0, 3) == 0);
        end
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (12) @(negedge ap_clk);
        request_dump();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
